// File: rtl/cv32e41p_fifo_dualpop_pkg.sv
// Shared types and the modulo-DEPTH pointer arithmetic for the dual-pop prefetch FIFO.
package cv32e41p_fifo_dualpop_pkg;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_cnt_e;

    // Pointers never exceed 8 bits because DEPTH is capped at 256.
    localparam int unsigned PTR_MAX_W = 8;

    // Caller guarantees ptr < depth and step <= 2 <= depth, so one subtraction is enough.
    function automatic logic [PTR_MAX_W-1:0] wrap_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                      input logic [1:0]           step,
                                                      input int unsigned          depth);
        int unsigned sum;
        sum = 32'(ptr) + 32'(step);
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return PTR_MAX_W'(sum);
    endfunction

endpackage

// File: rtl/cv32e41p_fifo_dualpop_if.sv
// Push, flush, pop-count and two-lane head view between the prefetcher/aligner and the FIFO.
interface cv32e41p_fifo_dualpop_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  flush_i;
    logic                  flush_but_first_i;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  empty_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  push_i;
    logic [DATA_WIDTH-1:0] data0_o;
    logic [DATA_WIDTH-1:0] data1_o;
    logic                  valid0_o;
    logic                  valid1_o;
    logic [1:0]            pop_i;

    modport master (
        output flush_i, flush_but_first_i, data_i, push_i, pop_i,
        input  full_o, almost_full_o, empty_o, cnt_o, data0_o, data1_o, valid0_o, valid1_o
    );

    modport slave (
        input  flush_i, flush_but_first_i, data_i, push_i, pop_i,
        output full_o, almost_full_o, empty_o, cnt_o, data0_o, data1_o, valid0_o, valid1_o
    );

endinterface

// File: rtl/cv32e41p_fifo_ptr.sv
// Modulo-DEPTH pointer register stepping by 0/1/2 per cycle, with clear and load.
// Registered output, one-cycle update; clear wins over load, load wins over step.
module cv32e41p_fifo_ptr
    import cv32e41p_fifo_dualpop_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic [1:0]    step_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_step;

    assign ptr_step = AW'(wrap_inc(PTR_MAX_W'(ptr_q), step_i, DEPTH));

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (load_i) begin
            ptr_d = load_val_i;
        end else begin
            ptr_d = ptr_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/cv32e41p_fifo_dualpop.sv
// Prefetch FIFO: one push per cycle, two oldest entries at the head, retires 0/1/2 per cycle.
// Head is combinational from state (plus data_i with FALL_THROUGH); a full FIFO still takes a push when a pop frees a slot.
module cv32e41p_fifo_dualpop
    import cv32e41p_fifo_dualpop_pkg::*;
#(
    parameter logic        FALL_THROUGH   = 1'b0,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned ALMOST_FULL_TH = DEPTH - 1,
    parameter int unsigned ADDR_DEPTH     = $clog2(DEPTH)
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    cv32e41p_fifo_dualpop_if.slave fifo_if
);

    localparam int unsigned     CW      = ADDR_DEPTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   TH_C    = CW'(ALMOST_FULL_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [ADDR_DEPTH-1:0] rptr;
    logic [ADDR_DEPTH-1:0] rptr_p1;
    logic [ADDR_DEPTH-1:0] wptr;

    logic       ft_push;
    logic       valid0;
    logic       valid1;
    logic       full;
    logic       normal;
    logic       flush_all;
    logic       flush_keep;
    logic       push_acc;
    logic       push_consumed;
    logic       mem_we;
    pop_cnt_e   head_avail;
    pop_cnt_e   npop;
    logic [1:0] npop_bits;
    logic [1:0] rd_step;
    logic [1:0] wr_step;

    assign ft_push = FALL_THROUGH & fifo_if.push_i;
    assign valid0  = (cnt_q != '0) | ft_push;
    assign valid1  = (cnt_q >= CW'(2)) | ((cnt_q == CW'(1)) & ft_push);
    assign full    = (cnt_q == DEPTH_C);

    // A flush-but-first on an empty FIFO has no head to keep, so it degrades to a full flush.
    assign flush_all  = fifo_if.flush_i | (fifo_if.flush_but_first_i & (cnt_q == '0));
    assign flush_keep = ~fifo_if.flush_i & fifo_if.flush_but_first_i & (cnt_q != '0);
    assign normal     = ~fifo_if.flush_i & ~fifo_if.flush_but_first_i;

    // Over-asking pops saturate at what the head can actually show.
    always_comb begin
        head_avail = POP_NONE;
        if (valid1) begin
            head_avail = POP_TWO;
        end else if (valid0) begin
            head_avail = POP_ONE;
        end
        npop = head_avail;
        if (fifo_if.pop_i < 2'(head_avail)) begin
            npop = pop_cnt_e'(fifo_if.pop_i);
        end
    end

    assign npop_bits = npop;

    // The pushed word sits in lane cnt_q; if that lane is popped now it never touches memory.
    assign push_acc      = fifo_if.push_i & (~full | (npop != POP_NONE));
    assign push_consumed = FALL_THROUGH & push_acc & (CW'(npop_bits) > cnt_q);
    assign mem_we        = normal & push_acc & ~push_consumed;

    assign rd_step = normal ? (npop_bits - {1'b0, push_consumed}) : 2'd0;
    assign wr_step = {1'b0, mem_we};

    assign rptr_p1 = ADDR_DEPTH'(wrap_inc(PTR_MAX_W'(rptr), 2'd1, DEPTH));

    cv32e41p_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (ADDR_DEPTH)
    ) u_rptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_all),
        .load_i     (1'b0),
        .load_val_i ('0),
        .step_i     (rd_step),
        .ptr_o      (rptr)
    );

    cv32e41p_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (ADDR_DEPTH)
    ) u_wptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_all),
        .load_i     (flush_keep),
        .load_val_i (rptr_p1),
        .step_i     (wr_step),
        .ptr_o      (wptr)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (flush_all) begin
            cnt_d = '0;
        end else if (flush_keep) begin
            cnt_d = CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(push_acc) - CW'(npop_bits);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Writing into the slot being popped is safe: reads see this cycle's register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wptr] <= fifo_if.data_i;
        end
    end

    assign fifo_if.data0_o       = (FALL_THROUGH && (cnt_q == '0))     ? fifo_if.data_i : mem_q[rptr];
    assign fifo_if.data1_o       = (FALL_THROUGH && (cnt_q == CW'(1))) ? fifo_if.data_i : mem_q[rptr_p1];
    assign fifo_if.valid0_o      = valid0;
    assign fifo_if.valid1_o      = valid1;
    assign fifo_if.empty_o       = ~valid0;
    assign fifo_if.full_o        = full;
    assign fifo_if.almost_full_o = (cnt_q >= TH_C);
    assign fifo_if.cnt_o         = cnt_q;

`ifdef CV32E41P_ASSERT_ON
    a_pop_code: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_if.pop_i != 2'd3);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        normal |-> (fifo_if.pop_i <= 2'(head_avail)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        normal |-> !(fifo_if.push_i && full && (fifo_if.pop_i == 2'd0)));
    a_depth_min: assert property (@(posedge clk_i) DEPTH >= 2);
    a_th_range: assert property (@(posedge clk_i)
        (ALMOST_FULL_TH >= 1) && (ALMOST_FULL_TH <= DEPTH));
`endif

endmodule
